// File: rtl/jpeg_dct_pkg.sv
// Shared types and output rounding for the fdct_zigzag DCT datapath.
package jpeg_dct_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned COEF_W    = 16;
  localparam int unsigned N_TERMS   = 8;
  localparam int unsigned FRAC_BITS = 14;
  localparam int unsigned OUT_W     = 12;

  localparam int unsigned MULT_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = MULT_W + $clog2(N_TERMS);
  // Width of the rounded sum before saturation (one extra bit absorbs the rounding carry).
  localparam int unsigned RND_W  = ACC_W - FRAC_BITS + 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [MULT_W-1:0] mult_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  dct_out_t;

  // Add one half LSB, drop FRAC_BITS (round half toward +inf), clamp to OUT_W.
  function automatic dct_out_t sat_round(input acc_t acc);
    logic signed [ACC_W:0]   r;
    logic signed [RND_W-1:0] s;
    r = $signed({acc[ACC_W-1], acc})
      + $signed({{(ACC_W + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}});
    s = r[ACC_W:FRAC_BITS];
    if ((s[RND_W-1:OUT_W-1] == '0) || (s[RND_W-1:OUT_W-1] == '1)) begin
      return s[OUT_W-1:0];
    end else if (s[RND_W-1]) begin
      return {1'b1, {(OUT_W - 1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W - 1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/dct_mult_reg.sv
// Stage M: registered full-width signed multiply plus term qualifiers.
module dct_mult_reg #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             ena_i,
  input  logic                             in_valid_i,
  input  logic                             in_first_i,
  input  logic signed [DATA_W-1:0]         din_i,
  input  logic signed [COEF_W-1:0]         coef_i,
  output logic signed [DATA_W+COEF_W-1:0]  mult_res_o,
  output logic                             m_valid_o,
  output logic                             m_first_o
);
  import jpeg_dct_pkg::*;

  logic signed [DATA_W+COEF_W-1:0] mult_res_q, mult_res_d;
  logic                            m_valid_q, m_first_q;

  // Product is computed at full width so no bits are lost before accumulation.
  always_comb begin
    mult_res_d = mult_res_q;
    if (in_valid_i) mult_res_d = din_i * coef_i;
  end

  // Pipeline register for the product and its valid/first qualifiers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mult_res_q <= '0;
      m_valid_q  <= 1'b0;
      m_first_q  <= 1'b0;
    end else if (ena_i) begin
      mult_res_q <= mult_res_d;
      m_valid_q  <= in_valid_i;
      m_first_q  <= in_valid_i & in_first_i;
    end
  end

  assign mult_res_o = mult_res_q;
  assign m_valid_o  = m_valid_q;
  assign m_first_o  = m_first_q;

endmodule

// File: rtl/dct_mac_accum.sv
// DCT multiply-accumulate: sums N_TERMS products, rounds/saturates, pulses out_valid.
module dct_mac_accum #(
  parameter int unsigned DATA_W    = jpeg_dct_pkg::DATA_W,
  parameter int unsigned COEF_W    = jpeg_dct_pkg::COEF_W,
  parameter int unsigned N_TERMS   = jpeg_dct_pkg::N_TERMS,
  parameter int unsigned FRAC_BITS = jpeg_dct_pkg::FRAC_BITS,
  parameter int unsigned OUT_W     = jpeg_dct_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic signed [DATA_W-1:0] din,
  input  logic signed [COEF_W-1:0] coef,
  output logic [OUT_W-1:0]         dout,
  output logic                     out_valid,
  output logic                     seq_err
);
  import jpeg_dct_pkg::*;

  localparam int unsigned MULT_W = DATA_W + COEF_W;
  localparam int unsigned CNT_W  = $clog2(N_TERMS);
  localparam int unsigned ACC_W  = MULT_W + CNT_W;

  logic signed [MULT_W-1:0] mult_res;
  logic                     m_valid, m_first;

  dct_mult_reg #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_mult (
    .clk_i      (clk),
    .rst_i      (rst),
    .ena_i      (ena),
    .in_valid_i (in_valid),
    .in_first_i (in_first),
    .din_i      (din),
    .coef_i     (coef),
    .mult_res_o (mult_res),
    .m_valid_o  (m_valid),
    .m_first_o  (m_first)
  );

  logic signed [ACC_W-1:0] acc_q, acc_d, mult_ext;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W:0]          cnt_inc;
  logic                    start;
  logic                    done_q, done_d;
  logic                    seq_err_q, seq_err_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        dout_q, dout_d;

  assign mult_ext = {{CNT_W{mult_res[MULT_W-1]}}, mult_res};

  // Stage A: accumulate; a stray non-first term with no open sequence starts a new one.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    cnt_inc   = '0;
    done_d    = 1'b0;
    seq_err_d = 1'b0;
    start     = m_first || (cnt_q == '0);
    if (m_valid) begin
      seq_err_d = m_first && (cnt_q != '0);
      if (start) begin
        acc_d   = mult_ext;
        cnt_inc = (CNT_W + 1)'(1);
      end else begin
        acc_d   = acc_q + mult_ext;
        cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
      end
      if (cnt_inc == (CNT_W + 1)'(N_TERMS)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  // Stage O: present the completed sum one edge after the last term lands in acc.
  always_comb begin
    out_valid_d = done_q;
    dout_d      = dout_q;
    if (done_q) dout_d = sat_round(acc_q);
  end

  // All state advances only under ena; reset overrides ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else if (ena) begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      seq_err_q   <= seq_err_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_dct_mac_accum.sv
// Directed self-checking bench for dct_mac_accum.
module tb_dct_mac_accum;

  logic               clk = 1'b0;
  logic               rst, ena, in_valid, in_first;
  logic signed [7:0]  din;
  logic signed [15:0] coef;
  logic [11:0]        dout;
  logic               out_valid, seq_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dct_mac_accum #(
    .DATA_W(8), .COEF_W(16), .N_TERMS(8), .FRAC_BITS(14), .OUT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_first(in_first),
    .din(din), .coef(coef), .dout(dout), .out_valid(out_valid), .seq_err(seq_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive one cycle of inputs (called at negedge), return at the next negedge.
  task automatic cyc(input logic e, input logic v, input logic f,
                     input logic signed [7:0] d, input logic signed [15:0] c);
    ena = e; in_valid = v; in_first = f; din = d; coef = c;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 8'sd0, 16'sd0);
  endtask

  // Feed 8 terms, then wait (bounded) for out_valid. lat counts cycles after the last term.
  task automatic feed8(input logic signed [7:0] d [8], input logic signed [15:0] c,
                       input logic use_first, output int lat, output logic [11:0] val,
                       output logic ov_after);
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, use_first && (k == 0), d[k], c);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      idle();
      lat++;
    end
    val = dout;
    idle();
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'sd0, 16'sd0);
    cyc(1'b0, 1'b0, 1'b0, 8'sd0, 16'sd0);
    checks++; if (dout !== 12'd0) begin errors++; $display("FAIL reset_dout: got %h want 000", dout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    rst = 1'b0;
  endtask

  task automatic test_round_up();
    logic signed [7:0] dv [8];
    int lat; logic [11:0] val; logic ova;
    dv = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1};
    feed8(dv, 16'sh2000, 1'b1, lat, val, ova);
    checks++; if (lat != 3) begin errors++; $display("FAIL round_up_latency: got %0d want 3", lat); end
    checks++; if (val !== 12'd1) begin errors++; $display("FAIL round_up_dout: got %h want 001", val); end
    checks++; if (ova !== 1'b0) begin errors++; $display("FAIL round_up_pulse_width: got %b want 0", ova); end
  endtask

  task automatic test_neg_round();
    logic signed [7:0] dv [8];
    int lat; logic [11:0] val; logic ova;
    dv = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, -8'sd1};
    feed8(dv, 16'sh2000, 1'b1, lat, val, ova);
    checks++; if (lat != 3) begin errors++; $display("FAIL neg_round_latency: got %0d want 3", lat); end
    checks++; if (val !== 12'd0) begin errors++; $display("FAIL neg_round_dout: got %h want 000", val); end
    dv = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    feed8(dv, 16'sh4000, 1'b1, lat, val, ova);
    checks++; if (val !== 12'd8) begin errors++; $display("FAIL ones_dout: got %h want 008", val); end
  endtask

  task automatic test_saturation();
    logic signed [7:0] dv [8];
    int lat; logic [11:0] val; logic ova;
    for (int k = 0; k < 8; k++) dv[k] = 8'sh80;
    feed8(dv, 16'sh8000, 1'b1, lat, val, ova);
    checks++; if (val !== 12'h7FF) begin errors++; $display("FAIL sat_pos_dout: got %h want 7ff", val); end
    feed8(dv, 16'sh7FFF, 1'b1, lat, val, ova);
    checks++; if (val !== 12'h800) begin errors++; $display("FAIL sat_neg_dout: got %h want 800", val); end
  endtask

  // Seq A (din 1..8, sum 36) directly followed by seq B (8 x -3, sum -24), stalled 3 cycles after 2 B terms.
  task automatic test_back_to_back();
    logic ov_rec [24];
    logic se_rec [24];
    logic [11:0] do_rec [24];
    logic exp_ov;
    for (int i = 0; i < 24; i++) begin
      if (i <= 7)       cyc(1'b1, 1'b1, i == 0, 8'(i + 1), 16'sh4000);
      else if (i <= 9)  cyc(1'b1, 1'b1, i == 8, -8'sd3, 16'sh4000);
      else if (i <= 12) cyc(1'b0, 1'b1, 1'b1, 8'sd99, 16'sh4000);
      else if (i <= 18) cyc(1'b1, 1'b1, 1'b0, -8'sd3, 16'sh4000);
      else              idle();
      ov_rec[i] = out_valid; se_rec[i] = seq_err; do_rec[i] = dout;
    end
    for (int i = 0; i < 24; i++) begin
      exp_ov = ((i >= 9) && (i <= 12)) || (i == 20);
      checks++; if (ov_rec[i] !== exp_ov) begin errors++; $display("FAIL b2b_out_valid[%0d]: got %b want %b", i, ov_rec[i], exp_ov); end
      checks++; if (se_rec[i] !== 1'b0) begin errors++; $display("FAIL b2b_seq_err[%0d]: got %b want 0", i, se_rec[i]); end
    end
    checks++; if (do_rec[9] !== 12'd36) begin errors++; $display("FAIL b2b_dout_a: got %h want 024", do_rec[9]); end
    checks++; if (do_rec[12] !== 12'd36) begin errors++; $display("FAIL b2b_dout_stall_hold: got %h want 024", do_rec[12]); end
    checks++; if (do_rec[19] !== 12'd36) begin errors++; $display("FAIL b2b_dout_between: got %h want 024", do_rec[19]); end
    checks++; if (do_rec[20] !== 12'hFE8) begin errors++; $display("FAIL b2b_dout_b: got %h want fe8", do_rec[20]); end
  endtask

  // 4 terms of din=5, then a new in_first: 8 terms of din=2 (sum 16).
  task automatic test_seq_err();
    logic ov_rec [17];
    logic se_rec [17];
    logic [11:0] do_rec [17];
    for (int i = 0; i < 17; i++) begin
      if (i <= 3)       cyc(1'b1, 1'b1, i == 0, 8'sd5, 16'sh4000);
      else if (i <= 11) cyc(1'b1, 1'b1, i == 4, 8'sd2, 16'sh4000);
      else              idle();
      ov_rec[i] = out_valid; se_rec[i] = seq_err; do_rec[i] = dout;
    end
    for (int i = 0; i < 17; i++) begin
      checks++; if (se_rec[i] !== (i == 5)) begin errors++; $display("FAIL serr_seq_err[%0d]: got %b want %b", i, se_rec[i], (i == 5)); end
      checks++; if (ov_rec[i] !== (i == 13)) begin errors++; $display("FAIL serr_out_valid[%0d]: got %b want %b", i, ov_rec[i], (i == 13)); end
    end
    checks++; if (do_rec[13] !== 12'd16) begin errors++; $display("FAIL serr_dout: got %h want 010", do_rec[13]); end
  endtask

  // Reset with ena low after 5 terms, then 8 terms without in_first must sum from zero.
  task automatic test_reset_mid();
    logic signed [7:0] dv [8];
    int lat; logic [11:0] val; logic ova;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0, 8'sd7, 16'sh4000);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 8'sd0, 16'sd0);
    checks++; if (dout !== 12'd0) begin errors++; $display("FAIL rstmid_dout: got %h want 000", dout); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rstmid_seq_err: got %b want 0", seq_err); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) dv[k] = 8'sd1;
    feed8(dv, 16'sh4000, 1'b0, lat, val, ova);
    checks++; if (lat != 3) begin errors++; $display("FAIL rstmid_latency: got %0d want 3", lat); end
    checks++; if (val !== 12'd8) begin errors++; $display("FAIL rstmid_fresh_dout: got %h want 008", val); end
    checks++; if (ova !== 1'b0) begin errors++; $display("FAIL rstmid_pulse_width: got %b want 0", ova); end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_first = 1'b0; din = '0; coef = '0;
    @(negedge clk);
    test_reset();
    test_round_up();
    test_neg_round();
    test_saturation();
    test_back_to_back();
    test_seq_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
